// File: rtl/mnist_infer_sequencer_if.sv
// Handshake and core-facing bus between the pixel source, the
// inference sequencer and the MNIST accelerator core.
interface mnist_infer_sequencer_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       core_rst;
   logic [7:0] pixel_out;
   logic [9:0] l1_addr;
   logic [6:0] l2_addr;
   logic       l2_en;
   logic [3:0] digit_in;
   logic [3:0] res_digit;
   logic       res_valid;
   logic       res_ready;
   logic       busy;

   modport master (
      input  s_data, s_valid, digit_in, res_ready,
      output s_ready, core_rst, pixel_out, l1_addr, l2_addr,
      output l2_en, res_digit, res_valid, busy
   );

   modport slave (
      output s_data, s_valid, digit_in, res_ready,
      input  s_ready, core_rst, pixel_out, l1_addr, l2_addr,
      input  l2_en, res_digit, res_valid, busy
   );
endinterface

// File: rtl/mnist_infer_sequencer.sv
// Streams one image into the MNIST core, sweeps layer 2, then
// returns the captured digit over a valid/ready result port.
module mnist_infer_sequencer #(
   parameter int NUM_PIXELS = 784,
   parameter int NUM_HIDDEN = 128,
   parameter int L1_LAT     = 4,
   parameter int L2_LAT     = 4
) (
   input logic clk,
   input logic rst,
   mnist_infer_sequencer_if.master bus
);

   localparam int MAX_LAT = (L1_LAT > L2_LAT) ? L1_LAT : L2_LAT;
   localparam int DW      = $clog2(MAX_LAT + 1);

   localparam logic [9:0]    LAST_PIX = 10'(NUM_PIXELS - 1);
   localparam logic [6:0]    LAST_HID = 7'(NUM_HIDDEN - 1);
   localparam logic [DW-1:0] L1_LAST  = DW'(L1_LAT - 1);
   localparam logic [DW-1:0] L2_LAST  = DW'(L2_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_L1_DRAIN,
      S_L2_RUN,
      S_L2_DRAIN,
      S_RESULT
   } state_e;

   state_e        state_q, state_d;
   logic [9:0]    cnt_q, cnt_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          s_ready_q, s_ready_d;
   logic          core_rst_q, core_rst_d;
   logic [7:0]    pixel_out_q, pixel_out_d;
   logic [9:0]    l1_addr_q, l1_addr_d;
   logic [6:0]    l2_addr_q, l2_addr_d;
   logic          l2_en_q, l2_en_d;
   logic [3:0]    res_digit_q, res_digit_d;
   logic          res_valid_q, res_valid_d;
   logic          busy_q, busy_d;
   logic          beat;

   assign beat = bus.s_valid & s_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drain_d     = drain_q;
      pixel_out_d = 8'd0;
      l1_addr_d   = l1_addr_q;
      l2_addr_d   = l2_addr_q;
      res_digit_d = res_digit_q;
      res_valid_d = res_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.s_valid) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_d     = 10'd0;
            l1_addr_d = 10'd0;
            state_d   = S_LOAD;
         end
         S_LOAD: begin
            // stall cycles present a zero pixel, which the MAC ignores
            if (beat) begin
               pixel_out_d = bus.s_data;
               l1_addr_d   = cnt_q;
               cnt_d       = cnt_q + 10'd1;
               if (cnt_q == LAST_PIX) begin
                  state_d = S_L1_DRAIN;
                  drain_d = '0;
               end
            end
         end
         S_L1_DRAIN: begin
            if (drain_q == L1_LAST) begin
               state_d   = S_L2_RUN;
               l2_addr_d = 7'd0;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_L2_RUN: begin
            if (l2_addr_q == LAST_HID) begin
               state_d = S_L2_DRAIN;
               drain_d = '0;
            end else begin
               l2_addr_d = l2_addr_q + 7'd1;
            end
         end
         S_L2_DRAIN: begin
            if (drain_q == L2_LAST) begin
               res_digit_d = bus.digit_in;
               res_valid_d = 1'b1;
               state_d     = S_RESULT;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end
         S_RESULT: begin
            if (res_valid_q & bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      s_ready_d  = (state_d == S_LOAD);
      core_rst_d = (state_d == S_CLEAR);
      l2_en_d    = (state_d == S_L2_RUN) || (state_d == S_L2_DRAIN);
      busy_d     = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 10'd0;
         drain_q     <= '0;
         s_ready_q   <= 1'b0;
         core_rst_q  <= 1'b1;
         pixel_out_q <= 8'd0;
         l1_addr_q   <= 10'd0;
         l2_addr_q   <= 7'd0;
         l2_en_q     <= 1'b0;
         res_digit_q <= 4'd0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         s_ready_q   <= s_ready_d;
         core_rst_q  <= core_rst_d;
         pixel_out_q <= pixel_out_d;
         l1_addr_q   <= l1_addr_d;
         l2_addr_q   <= l2_addr_d;
         l2_en_q     <= l2_en_d;
         res_digit_q <= res_digit_d;
         res_valid_q <= res_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.s_ready   = s_ready_q;
   assign bus.core_rst  = core_rst_q;
   assign bus.pixel_out = pixel_out_q;
   assign bus.l1_addr   = l1_addr_q;
   assign bus.l2_addr   = l2_addr_q;
   assign bus.l2_en     = l2_en_q;
   assign bus.res_digit = res_digit_q;
   assign bus.res_valid = res_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mnist_infer_sequencer.sv
// Bench for mnist_infer_sequencer: pixel and result scoreboards plus
// a small core model whose digit is only valid once layer 2 settles.
module tb_mnist_infer_sequencer;
   localparam int NPIX  = 784;
   localparam int NHID  = 128;
   localparam int L1    = 4;
   localparam int L2    = 4;
   localparam int T_RES = 785 + L1 + NHID + L2;
   localparam int LIM   = 4000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mnist_infer_sequencer_if ifc ();

   mnist_infer_sequencer #(
      .NUM_PIXELS(NPIX),
      .NUM_HIDDEN(NHID),
      .L1_LAT(L1),
      .L2_LAT(L2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [17:0] pix_q[$];
   logic [3:0]  res_q[$];
   logic [3:0]  core_digit = 4'd0;
   int          l2_cnt = 0;
   bit          l2_was = 1'b0;
   int          exp_addr = 0;
   int          mon_beats = 0;

   // core model: digit_out settles L2_LAT cycles after the last l2_addr
   assign ifc.digit_in = (ifc.l2_en && l2_cnt >= NHID + L2 - 1)
                         ? core_digit : 4'hF;

   always @(posedge clk) begin
      bit bt, stl, hs;
      logic [7:0]  d;
      logic [9:0]  ap;
      logic [3:0]  dg;
      logic [17:0] e;
      logic [3:0]  er;
      bt  = !rst && ifc.s_valid && ifc.s_ready;
      stl = !rst && !ifc.s_valid && ifc.s_ready;
      hs  = !rst && ifc.res_valid && ifc.res_ready;
      d   = ifc.s_data;
      ap  = ifc.l1_addr;
      dg  = ifc.res_digit;
      if (ifc.core_rst === 1'b1) exp_addr = 0;
      if (bt) begin
         pix_q.push_back({10'(exp_addr), d});
         exp_addr++;
         mon_beats++;
      end
      #1;
      if (bt) begin
         e = pix_q.pop_front();
         checks++;
         if ({ifc.l1_addr, ifc.pixel_out} !== e) begin
            errors++;
            $display("FAIL beat: l1_addr=%0d pixel=%0h required l1_addr=%0d pixel=%0h",
                     ifc.l1_addr, ifc.pixel_out, e[17:8], e[7:0]);
         end
      end else if (stl) begin
         checks++;
         if (ifc.pixel_out !== 8'd0 || ifc.l1_addr !== ap) begin
            errors++;
            $display("FAIL stall: l1_addr=%0d pixel=%0h required l1_addr=%0d pixel=0",
                     ifc.l1_addr, ifc.pixel_out, ap);
         end
      end
      if (hs) begin
         checks++;
         if (res_q.size() == 0) begin
            errors++;
            $display("FAIL result: unexpected digit %0d, required none", dg);
         end else begin
            er = res_q.pop_front();
            if (dg !== er) begin
               errors++;
               $display("FAIL result: digit=%0d required %0d", dg, er);
            end
         end
      end
      if (ifc.l2_en === 1'b1) begin
         l2_cnt = l2_was ? l2_cnt + 1 : 0;
         checks++;
         if (ifc.l2_addr !== 7'((l2_cnt > NHID - 1) ? NHID - 1 : l2_cnt)) begin
            errors++;
            $display("FAIL l2_addr: got %0d at l2 cycle %0d", ifc.l2_addr, l2_cnt);
         end
      end else begin
         l2_cnt = 0;
      end
      l2_was = (ifc.l2_en === 1'b1);
   end

   // Called at a negedge with the DUT idle; cyc ends on the cycle after
   // the last driven beat, counted from the first CLEAR cycle as 0.
   task automatic drive_image(input bit stall, input int stop_at,
                              output int cyc, output int crst);
      int idx;
      bit b, stalled;
      idx = 0;
      stalled = 1'b0;
      cyc = -1;
      crst = 0;
      ifc.s_data  = 8'd0;
      ifc.s_valid = 1'b1;
      while (idx < stop_at && cyc < LIM) begin
         b = ifc.s_valid && ifc.s_ready;
         @(negedge clk);
         cyc++;
         if (ifc.core_rst) crst++;
         if (b) begin
            idx++;
            stalled = 1'b0;
         end
         ifc.s_data = 8'(idx);
         if (stall && idx % 4 == 3 && !stalled) begin
            ifc.s_valid = 1'b0;
            stalled = 1'b1;
         end else begin
            ifc.s_valid = 1'b1;
         end
      end
      ifc.s_valid = 1'b0;
   endtask

   task automatic wait_res(inout int cyc, inout int crst, output int l2hi);
      l2hi = 0;
      while (!ifc.res_valid && cyc < LIM) begin
         @(negedge clk);
         cyc++;
         if (ifc.l2_en) l2hi++;
         if (ifc.core_rst) crst++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      ifc.s_valid = 1'b0;
      ifc.s_data = 8'd0;
      ifc.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b1) begin
         errors++;
         $display("FAIL reset core_rst: %b required 1", ifc.core_rst);
      end
      checks++;
      if ({ifc.s_ready, ifc.l2_en, ifc.res_valid, ifc.busy, ifc.pixel_out,
           ifc.l1_addr, ifc.l2_addr, ifc.res_digit} !== 33'd0) begin
         errors++;
         $display("FAIL reset outputs: ready=%b l2en=%b rv=%b busy=%b px=%0h a1=%0d a2=%0d dg=%0d required all 0",
                  ifc.s_ready, ifc.l2_en, ifc.res_valid, ifc.busy,
                  ifc.pixel_out, ifc.l1_addr, ifc.l2_addr, ifc.res_digit);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b0 || ifc.busy !== 1'b0 || ifc.s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset release: core_rst=%b busy=%b ready=%b required 0 0 0",
                  ifc.core_rst, ifc.busy, ifc.s_ready);
      end
   endtask

   task automatic test_stream;
      int cyc, crst, l2hi;
      core_digit = 4'd7;
      ifc.res_ready = 1'b1;
      res_q.push_back(4'd7);
      mon_beats = 0;
      drive_image(1'b0, NPIX, cyc, crst);
      wait_res(cyc, crst, l2hi);
      checks++;
      if (mon_beats !== NPIX) begin
         errors++;
         $display("FAIL stream beats: %0d required %0d", mon_beats, NPIX);
      end
      checks++;
      if (cyc !== T_RES) begin
         errors++;
         $display("FAIL stream res_valid cycle: %0d required %0d", cyc, T_RES);
      end
      checks++;
      if (ifc.res_digit !== 4'd7) begin
         errors++;
         $display("FAIL stream digit: %0d required 7", ifc.res_digit);
      end
      checks++;
      if (l2hi !== NHID + L2) begin
         errors++;
         $display("FAIL stream l2_en cycles: %0d required %0d", l2hi, NHID + L2);
      end
      checks++;
      if (crst !== 1) begin
         errors++;
         $display("FAIL stream core_rst pulses: %0d required 1", crst);
      end
      @(negedge clk);
      checks++;
      if (ifc.busy !== 1'b0 || ifc.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL stream back to idle: busy=%b rv=%b required 0 0",
                  ifc.busy, ifc.res_valid);
      end
   endtask

   task automatic test_stalls;
      int cyc, crst, l2hi;
      core_digit = 4'd5;
      res_q.push_back(4'd5);
      mon_beats = 0;
      drive_image(1'b1, NPIX, cyc, crst);
      wait_res(cyc, crst, l2hi);
      checks++;
      if (mon_beats !== NPIX) begin
         errors++;
         $display("FAIL stalls beats: %0d required %0d", mon_beats, NPIX);
      end
      checks++;
      if (cyc !== T_RES + NPIX / 4) begin
         errors++;
         $display("FAIL stalls res_valid cycle: %0d required %0d", cyc, T_RES + NPIX / 4);
      end
      checks++;
      if (ifc.res_digit !== 4'd5) begin
         errors++;
         $display("FAIL stalls digit: %0d required 5", ifc.res_digit);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      int cyc, crst, l2hi;
      core_digit = 4'd2;
      ifc.res_ready = 1'b0;
      res_q.push_back(4'd2);
      drive_image(1'b0, NPIX, cyc, crst);
      wait_res(cyc, crst, l2hi);
      checks++;
      if (cyc !== T_RES) begin
         errors++;
         $display("FAIL bp res_valid cycle: %0d required %0d", cyc, T_RES);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if ({ifc.res_valid, ifc.res_digit, ifc.l2_en, ifc.s_ready} !== 7'b1_0010_00) begin
            errors++;
            $display("FAIL bp hold %0d: rv=%b dg=%0d l2en=%b ready=%b required 1 2 0 0",
                     i, ifc.res_valid, ifc.res_digit, ifc.l2_en, ifc.s_ready);
         end
      end
      ifc.res_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.busy !== 1'b0 || ifc.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp release: busy=%b rv=%b required 0 0", ifc.busy, ifc.res_valid);
      end
      ifc.s_valid = 1'b1;
      ifc.s_data = 8'd0;
      @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b1 || ifc.busy !== 1'b1) begin
         errors++;
         $display("FAIL bp new clear: core_rst=%b busy=%b required 1 1",
                  ifc.core_rst, ifc.busy);
      end
      ifc.s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mid_reset;
      int cyc, crst, l2hi;
      int tmo;
      core_digit = 4'd9;
      drive_image(1'b0, 400, cyc, crst);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b1 ||
          {ifc.s_ready, ifc.l2_en, ifc.res_valid, ifc.busy, ifc.pixel_out,
           ifc.l1_addr, ifc.l2_addr, ifc.res_digit} !== 33'd0) begin
         errors++;
         $display("FAIL midrst outputs: core_rst=%b ready=%b busy=%b px=%0h a1=%0d required 1 0 0 0 0",
                  ifc.core_rst, ifc.s_ready, ifc.busy, ifc.pixel_out, ifc.l1_addr);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b0 || ifc.busy !== 1'b0) begin
         errors++;
         $display("FAIL midrst release: core_rst=%b busy=%b required 0 0",
                  ifc.core_rst, ifc.busy);
      end
      tmo = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifc.res_valid) tmo++;
      end
      checks++;
      if (tmo !== 0) begin
         errors++;
         $display("FAIL midrst no result: res_valid seen %0d cycles required 0", tmo);
      end
      core_digit = 4'd4;
      res_q.push_back(4'd4);
      drive_image(1'b0, NPIX, cyc, crst);
      wait_res(cyc, crst, l2hi);
      checks++;
      if (crst !== 1) begin
         errors++;
         $display("FAIL midrst core_rst pulses: %0d required 1", crst);
      end
      checks++;
      if (cyc !== T_RES || ifc.res_digit !== 4'd4) begin
         errors++;
         $display("FAIL midrst rerun: cycle=%0d digit=%0d required %0d 4",
                  cyc, ifc.res_digit, T_RES);
      end
      @(negedge clk);
   endtask

   task automatic test_boundary;
      int cyc, crst, l2hi, mb;
      core_digit = 4'd6;
      ifc.res_ready = 1'b0;
      res_q.push_back(4'd6);
      drive_image(1'b0, NPIX, cyc, crst);
      wait_res(cyc, crst, l2hi);
      mb = mon_beats;
      ifc.res_ready = 1'b1;
      ifc.s_valid = 1'b1;
      ifc.s_data = 8'hAA;
      @(negedge clk);
      checks++;
      if (ifc.busy !== 1'b0 || ifc.s_ready !== 1'b0 || mon_beats !== mb) begin
         errors++;
         $display("FAIL bnd idle: busy=%b ready=%b beats=%0d required 0 0 %0d",
                  ifc.busy, ifc.s_ready, mon_beats, mb);
      end
      @(negedge clk);
      checks++;
      if (ifc.core_rst !== 1'b1 || ifc.s_ready !== 1'b0 || mon_beats !== mb) begin
         errors++;
         $display("FAIL bnd clear: core_rst=%b ready=%b beats=%0d required 1 0 %0d",
                  ifc.core_rst, ifc.s_ready, mon_beats, mb);
      end
      @(negedge clk);
      checks++;
      if (ifc.s_ready !== 1'b1 || ifc.core_rst !== 1'b0) begin
         errors++;
         $display("FAIL bnd load: ready=%b core_rst=%b required 1 0",
                  ifc.s_ready, ifc.core_rst);
      end
      @(negedge clk);
      checks++;
      if (ifc.l1_addr !== 10'd0 || ifc.pixel_out !== 8'hAA || mon_beats !== mb + 1) begin
         errors++;
         $display("FAIL bnd first beat: a1=%0d px=%0h beats=%0d required 0 aa %0d",
                  ifc.l1_addr, ifc.pixel_out, mon_beats, mb + 1);
      end
      ifc.s_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stalls();
      test_backpressure();
      test_mid_reset();
      test_boundary();
      checks++;
      if (res_q.size() !== 0) begin
         errors++;
         $display("FAIL pending results: %0d left required 0", res_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
